bcd_counter: RTL and testbench
==============================

Name: bcd_counter

Overview:
Two-digit (00–99) synchronous BCD up/down counter with parallel load, synchronous clear and a terminal-count/wrap indicator. It is the top-level user block for a TinyTapeout-style tile and uses the standard tile pin set. The count is presented on uo_out as packed BCD (tens:ones); status leaves on the upper bidirectional pins.

Parameters:
none (fixed 2-digit BCD; no configurable width)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
ena  input  1  tile enable; when 0 all state holds
ui_in  input  8  [0]=cnt_en, [1]=dir (0 up, 1 down), [2]=clr, [3]=load, [7:4]=load value for ones digit
uo_out  output  8  [7:4]=tens BCD digit, [3:0]=ones BCD digit (registered)
uio_in  input  8  [3:0]=load value for tens digit; [7:4] ignored
uio_out  output  8  [7]=tc (terminal count, combinational), [6]=wrap (sticky, registered), [5:4]=0, [3:0]=0
uio_oe  output  8  constant 8'hF0 (uio[7:4] outputs, uio[3:0] inputs)

Behaviour:
- One clock domain. Reset is synchronous and active-low: rst_n=0 at a rising edge sets tens=0, ones=0, wrap=0. After reset, uo_out=8'h00 and uio_out=8'h00.
- Priority per rising edge: rst_n=0 > ena=0 (hold everything) > clr > load > cnt_en > hold.
- clr=1: tens=0, ones=0, wrap=0.
- load=1 (clr=0): ones<=ui_in[7:4] and tens<=uio_in[3:0]. Each nibble greater than 9 (A–F) is loaded as 0. wrap<=0.
- cnt_en=1, dir=0 (up): ones+1; ones=9 → ones=0 and tens+1; tens=9 and ones=9 → 00 and wrap<=1.
- cnt_en=1, dir=1 (down): ones-1; ones=0 → ones=9 and tens-1; 00 → 99 and wrap<=1.
- Count latency is 1 cycle: the new value is visible on uo_out after the same rising edge.
- Digits never hold values greater than 9 under any input sequence.
- wrap is sticky: it stays at 1 until reset, clr or load.
- tc = ena & rst_n & cnt_en & ~clr & ~load & ((dir=0 & count=99) | (dir=1 & count=00)). tc is combinational and asserts in the cycle before the wrapping edge.
- dir may change on any cycle; it takes effect on the next counting edge with no glitch state.
- Reset mid-count takes priority over every other control.
- uio_oe is constant regardless of reset.

Test Plan:
- Reset: rst_n=0 for 2 cycles with cnt_en=1 → uo_out=8'h00, uio_out=8'h00, uio_oe=8'hF0.
- Up count with ena=1, cnt_en=1, dir=0: 9 clocks → uo_out=8'h09; 1 more → 8'h10. 99 clocks from 00 → 8'h99 with tc=1. Next clock → 8'h00 with uio_out[6]=1.
- Down count from 00 with dir=1: 1 clock → 8'h99 and wrap=1. Load 8'h10 (uio_in=4'h1, ui_in[7:4]=0, load=1), then down 1 → 8'h09 and wrap=0.
- Invalid load: uio_in[3:0]=4'hC, ui_in[7:4]=4'h7, load=1 → uo_out=8'h07.
- Priority: load=1 with cnt_en=1 → loaded value, not incremented. clr=1 with load=1 → 8'h00. ena=0 with cnt_en=1 for 5 clocks → value unchanged.
- Mid-operation reset: count to 8'h42, then pulse rst_n=0 for 1 clock → 8'h00, wrap=0; counting then resumes from 00.

Source files
------------

// File: rtl/bcd_counter.sv
// Two-digit BCD up/down counter tile: load, clear, sticky wrap, terminal count.
// Ports: clk, rst_n (sync, active-low), ena, ui_in, uio_in in; uo_out, uio_out, uio_oe out.
module bcd_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       cnt_en;
  logic       dir;
  logic       clr;
  logic       load;
  logic [3:0] ld_ones;
  logic [3:0] ld_tens;

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       wrap_q, wrap_d;
  logic       at_max;
  logic       at_min;
  logic       tc;

  assign cnt_en = ui_in[0];
  assign dir    = ui_in[1];
  assign clr    = ui_in[2];
  assign load   = ui_in[3];

  // Non-decimal nibbles load as zero so digits stay 0..9.
  assign ld_ones = (ui_in[7:4] > 4'd9) ? 4'd0 : ui_in[7:4];
  assign ld_tens = (uio_in[3:0] > 4'd9) ? 4'd0 : uio_in[3:0];

  assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);
  assign at_min = (tens_q == 4'd0) && (ones_q == 4'd0);

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    wrap_d = wrap_q;
    if (ena) begin
      priority case (1'b1)
        clr: begin
          ones_d = 4'd0;
          tens_d = 4'd0;
          wrap_d = 1'b0;
        end
        load: begin
          ones_d = ld_ones;
          tens_d = ld_tens;
          wrap_d = 1'b0;
        end
        cnt_en: begin
          if (!dir) begin
            if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              if (tens_q == 4'd9) begin
                tens_d = 4'd0;
                wrap_d = 1'b1;
              end else begin
                tens_d = tens_q + 4'd1;
              end
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end else begin
            if (ones_q == 4'd0) begin
              ones_d = 4'd9;
              if (tens_q == 4'd0) begin
                tens_d = 4'd9;
                wrap_d = 1'b1;
              end else begin
                tens_d = tens_q - 4'd1;
              end
            end else begin
              ones_d = ones_q - 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      wrap_q <= 1'b0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      wrap_q <= wrap_d;
    end
  end

  // Flags the edge that is about to wrap, so only a real count edge qualifies.
  assign tc = ena & rst_n & cnt_en & ~clr & ~load &
              ((~dir & at_max) | (dir & at_min));

  assign uo_out  = {tens_q, ones_q};
  assign uio_out = {tc, wrap_q, 6'b0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_bcd_counter.sv
// Directed self-checking bench for bcd_counter.
// Expected values are hand-computed constants.
module tb_bcd_counter;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp;
  int n_bad;

  bcd_counter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h",
             tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h01;
    uio_in = 8'h00;

    // Reset with counting requested
    tick(2);
    chk("rst_cnt", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hF0);

    // Up count and ones->tens carry
    rst_n = 1'b1;
    tick(9);
    chk("up_09", uo_out, 8'h09);
    tick(1);
    chk("up_10", uo_out, 8'h10);

    // Clear, then 99 up-counts to the top
    ui_in = 8'h05;
    tick(1);
    chk("clr", uo_out, 8'h00);
    ui_in = 8'h01;
    tick(99);
    chk("up_99", uo_out, 8'h99);
    chk("tc_up", uio_out, 8'h80);
    tick(1);
    chk("wrap_up", uo_out, 8'h00);
    chk("wrap_up_f", uio_out, 8'h40);

    // Down from 00 wraps to 99
    ui_in = 8'h03;
    #1;
    chk("tc_dn", uio_out, 8'hC0);
    tick(1);
    chk("wrap_dn", uo_out, 8'h99);
    chk("wrap_dn_f", uio_out, 8'h40);

    // Load 10 clears wrap, then borrow to 09
    uio_in = 8'h01;
    ui_in  = 8'h08;
    tick(1);
    chk("ld_10", uo_out, 8'h10);
    chk("ld_wrap", uio_out, 8'h00);
    ui_in = 8'h03;
    tick(1);
    chk("dn_09", uo_out, 8'h09);
    chk("dn_09_f", uio_out, 8'h00);

    // Non-decimal tens nibble loads as 0
    uio_in = 8'h0C;
    ui_in  = 8'h78;
    tick(1);
    chk("ld_bad", uo_out, 8'h07);

    // Load beats count
    uio_in = 8'h03;
    ui_in  = 8'h59;
    tick(1);
    chk("ld_vs_cnt", uo_out, 8'h35);

    // Load at 99 with count: tc masked
    uio_in = 8'h09;
    ui_in  = 8'h98;
    tick(1);
    ui_in  = 8'h99;
    #1;
    chk("tc_ld_mask", uio_out, 8'h00);

    // Clear beats load
    ui_in = 8'h5C;
    tick(1);
    chk("clr_vs_ld", uo_out, 8'h00);

    // Tile disabled holds value
    uio_in = 8'h04;
    ui_in  = 8'h28;
    tick(1);
    chk("ld_42", uo_out, 8'h42);
    ena   = 1'b0;
    ui_in = 8'h01;
    tick(5);
    chk("ena_hold", uo_out, 8'h42);
    chk("ena_uio", uio_out, 8'h00);

    // Set wrap, count to 42, then reset mid-count
    ena    = 1'b1;
    uio_in = 8'h09;
    ui_in  = 8'h98;
    tick(1);
    ui_in = 8'h01;
    tick(1);
    chk("wrap_set", uio_out, 8'h40);
    tick(42);
    chk("cnt_42", uo_out, 8'h42);
    chk("wrap_stk", uio_out, 8'h40);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst", uo_out, 8'h00);
    chk("mid_rst_f", uio_out, 8'h00);
    rst_n = 1'b1;
    tick(1);
    chk("resume", uo_out, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
